fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single push port of the asynchronous FIFO (`fifo_top`) among several producers in the write-clock domain. It grants one requester at a time for a bounded burst and forwards that requester's data and push onto the FIFO write interface. It throttles all producers on FIFO full, so no push is ever issued into a full FIFO. It sits between the producer blocks and the `fifo_if` write side.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be a power of 2 and at least 2.
- `DATA_WIDTH`, default 8: FIFO word width; matches `data_in` of `fifo_if`.
- `MAX_BURST`, default 4: maximum consecutive transfers per grant; allowed range 1..16.
- `wr_clk` input 1: write-domain clock; the only clock.
- `wr_rst` input 1: reset, asynchronous, active-low.
- `req_valid` input NUM_REQ: per-requester data-valid.
- `req_data` input NUM_REQ*DATA_WIDTH: requester i's data in slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` output NUM_REQ: per-requester accept; one-hot or zero.
- `fifo_full` input 1: FIFO full flag, write domain.
- `fifo_push` output 1: push strobe to the FIFO.
- `fifo_data_in` output DATA_WIDTH: data to the FIFO.
- `grant_id` output log2(NUM_REQ): index of the current or last granted requester.
- `busy` output 1: high while in state GRANT.

## Operation
- A transfer on requester i occurs when `req_valid[i] && req_ready[i]` is true at a `wr_clk` rising edge.
- `req_ready[i]` = (state==GRANT) && (grant_id==i) && !fifo_full. It is combinational.
- `fifo_push` = OR of all transfers. `fifo_data_in` = `req_data` slice selected by `grant_id`. Both are combinational, so a transfer is the push, with zero latency.
- FSM has two states:
  - IDLE: if any `req_valid` is set, select the first valid index searching from `last_grant+1` upward, modulo NUM_REQ. Load `grant_id` and `last_grant` with that index, clear `burst_cnt`, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: each transfer increments `burst_cnt`. Return to IDLE when either of these holds:
    - a transfer occurs with `burst_cnt==MAX_BURST-1`;
    - `req_valid[grant_id]` is low.
- While `fifo_full` is high in GRANT, stay in GRANT with `burst_cnt` held and no push. There is no timeout.
- Changes to a non-granted requester's valid do not affect the current burst.
- `burst_cnt` is 5 bits wide and saturates logically at MAX_BURST-1; it never wraps within a burst.

## Timing
- Reset values:
  - state = IDLE
  - `grant_id` = 0
  - `last_grant` = NUM_REQ-1, so the first grant goes to requester 0
  - `burst_cnt` = 0
  - `busy` = 0
  - `req_ready` = 0
  - `fifo_push` = 0
  - `fifo_data_in` = requester 0 slice (don't-care value, not qualified)
- Reset asserted mid-burst forces the state above immediately and asynchronously. `fifo_push` drops in the same instant.
- Grant latency is 1 cycle. A valid first seen in IDLE at edge n allows its first transfer at edge n+1.
- Inter-burst bubble is exactly 1 cycle: the GRANT→IDLE edge, then the IDLE→GRANT edge.
- Sustained throughput with all requesters valid and FIFO not full is MAX_BURST words per MAX_BURST+1 cycles.
- `fifo_full` deasserting enables a transfer in the same cycle.

## Configuration
- `FIFO_ARB_PRIO_EN` defined:
  - In IDLE, requester 0 is selected whenever `req_valid[0]` is set, regardless of RR order.
  - A grant to requester 0 made by this priority rule does not update `last_grant`, so the RR order among the other requesters is preserved.
  - Requester 0's bursts are still limited to MAX_BURST.
- `FIFO_ARB_PRIO_EN` undefined: pure round-robin. Requester 0 has no special treatment.

## Test plan
- **Reset then single requester.** Hold `wr_rst` low for 2 cycles, release, then raise `req_valid[2]` with data 0xA0..0xA5. Required: `busy` 1 cycle later. Pushes of 0xA0..0xA3, then a 1-cycle gap, then 0xA4..0xA5. `grant_id`=2 throughout.
- **All four requesters valid continuously, FIFO never full.** Required: grant order 0,1,2,3,0. Each burst is exactly 4 pushes separated by 1 idle cycle. 16 pushes in 20 cycles.
- **Full stall.** Requester 1 mid-burst at `burst_cnt`=2, then force `fifo_full`=1 for 5 cycles. Required: no push and `req_ready`=0 during the stall. Exactly 2 more pushes after release, then IDLE.
- **Early release.** Requester 3 drops `req_valid` after 2 transfers. Required: IDLE on the next edge. The next grant goes to 0 if it is valid (wrap-around from 3).
- **Async reset mid-burst.** Pull `wr_rst` low between edges during a push. Required: `fifo_push`, `req_ready` and `busy` all 0 immediately. After release, the first grant goes to requester 0.
- **`FIFO_ARB_PRIO_EN` build, all four requesters valid.** Required grant sequence: 0,0,0… for as long as `req_valid[0]` stays high. Dropping requester 0 gives order 1,2,3. Requester 0 re-asserting wins at the next IDLE.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ write-domain producers.
// Optional FIFO_ARB_PRIO_EN: requester 0 wins every IDLE pick without disturbing RR order.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e        state_q;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] last_q;
    logic [4:0]    burst_q;
    logic [4:0]    burst_d;
    logic [IW-1:0] pick;
    logic          prio_hit;
    logic          xfer;
    logic          last_beat;

`ifdef FIFO_ARB_PRIO_EN
    assign prio_hit = req_valid[0];
`else
    assign prio_hit = 1'b0;
`endif

    // Scan downward so the final assignment is the first valid index after last_q.
    always_comb begin
        logic [IW-1:0] idx;
        idx  = '0;
        pick = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_q + IW'(k);
            if (req_valid[idx]) pick = idx;
        end
        if (prio_hit) pick = '0;
    end

    always_comb begin
        req_ready = '0;
        if (state_q == GRANT && !fifo_full) req_ready[grant_q] = 1'b1;
    end

    assign xfer         = |(req_valid & req_ready);
    assign fifo_push    = xfer;
    assign fifo_data_in = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id     = grant_q;
    assign busy         = (state_q == GRANT);
    assign last_beat    = (burst_q == 5'(MAX_BURST - 1));
    assign burst_d      = burst_q + 5'd1;

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q <= pick;
                        if (!prio_hit) last_q <= pick;
                        burst_q <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        if (last_beat) state_q <= IDLE;
                        else           burst_q <= burst_d;
                    end else if (!req_valid[grant_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
